// File: rtl/mag_cmp_pkg.sv
// Shared types and the per-digit compare function for the sequential magnitude comparator.
package mag_cmp_pkg;

   // Widest digit the compare function handles; narrower digits are zero-extended.
   localparam int DIGIT_MAX = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic g;
      logic l;
      logic e;
   } cmp_res_t;

   function automatic cmp_res_t digit_cmp(input logic [DIGIT_MAX-1:0] a_d,
                                          input logic [DIGIT_MAX-1:0] b_d);
      cmp_res_t r;
      r.g = (a_d > b_d);
      r.l = (a_d < b_d);
      r.e = (a_d == b_d);
      return r;
   endfunction

endpackage

// File: rtl/mag_cmp_digit.sv
// Combinational DIGIT-bit unsigned comparator feeding the sequential compare FSM.
module mag_cmp_digit
   import mag_cmp_pkg::*;
#(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   output cmp_res_t         res
);

   assign res = digit_cmp(DIGIT_MAX'(a_d), DIGIT_MAX'(b_d));

endmodule

// File: rtl/mag_cmp_seq.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per cycle, with early exit
// on the first differing digit and a valid/ready result handshake.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | comparing digit idx, one digit per cycle
//   DONE  | result held on g/l/e/ndig, out_valid=1
module mag_cmp_seq
   import mag_cmp_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int DIGIT = 4,
   localparam int NDIG  = WIDTH / DIGIT,
   localparam int CW    = $clog2(NDIG + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             g,
   output logic             l,
   output logic             e,
   output logic [CW-1:0]    ndig
);

   // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
   localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [CW-1:0]    idx;
   logic [CW-1:0]    count;
   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   cmp_res_t         dig;
   logic             accept;
   logic             resolve;

   assign a_dig = a_q[idx*DIGIT +: DIGIT];
   assign b_dig = b_q[idx*DIGIT +: DIGIT];

   mag_cmp_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d (a_dig),
      .b_d (b_dig),
      .res (dig)
   );

   assign accept  = (state == IDLE) && in_valid;
   assign resolve = (state == RUN) && (dig.g || dig.l || (idx == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (resolve)   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         idx   <= '0;
         count <= '0;
         g     <= 1'b0;
         l     <= 1'b0;
         e     <= 1'b0;
         ndig  <= '0;
      end else if (accept) begin
         a_q   <= signed_mode ? (a ^ SIGN_MASK) : a;
         b_q   <= signed_mode ? (b ^ SIGN_MASK) : b;
         idx   <= CW'(NDIG - 1);
         count <= '0;
      end else if (state == RUN) begin
         count <= count + 1'b1;
         if (resolve) begin
            g    <= dig.g;
            l    <= dig.l;
            e    <= dig.e;
            ndig <= count + 1'b1;
         end else begin
            idx  <= idx - 1'b1;
         end
      end else if ((state == DONE) && out_ready) begin
         g <= 1'b0;
         l <= 1'b0;
         e <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Bench for mag_cmp_seq: directed cases on a 16/4 instance plus scoreboarded random
// sweeps on four widths/digit sizes running in parallel.
module tb_mag_cmp_seq;

   localparam int W     = 16;
   localparam int D     = 4;
   localparam int ND    = W / D;
   localparam int CWD   = $clog2(ND + 1);
   localparam int NPAIR = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           signed_mode;
   logic           out_valid;
   logic           out_ready;
   logic           g;
   logic           l;
   logic           e;
   logic [CWD-1:0] ndig;

   logic           sw_rst_n;

   int n_chk = 0;
   int n_err = 0;
   int exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   mag_cmp_seq #(.WIDTH(W), .DIGIT(D)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .g           (g),
      .l           (l),
      .e           (e),
      .ndig        (ndig)
   );

   // Expected entry layout: {ndig, g, l, e}.
   task automatic run_cmp(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tsm, input int eg, input int el, input int ee,
                          input int endig, input int elat);
      int lat;
      int pk;
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
      exp_q.push_back((endig << 3) | (eg << 2) | (el << 1) | ee);
      a = ta; b = tb_v; signed_mode = tsm; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom); signed_mode = ~tsm;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 40);
      chk({tag, "_lat"}, 32'(lat), 32'(elat));
      pk = exp_q.pop_front();
      chk({tag, "_gle"}, 32'({g, l, e}), 32'(pk & 7));
      chk({tag, "_ndig"}, 32'(ndig), 32'(pk >> 3));
   endtask

   task automatic release_res(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_ov0"}, 32'(out_valid), 32'd0);
      chk({tag, "_ir1"}, 32'(in_ready), 32'd1);
      chk({tag, "_clr"}, 32'({g, l, e}), 32'd0);
   endtask

   function automatic int cfg_w(input int i);
      case (i)
         0:       return 16;
         1:       return 16;
         2:       return 8;
         default: return 12;
      endcase
   endfunction

   function automatic int cfg_d(input int i);
      case (i)
         0:       return 4;
         1:       return 1;
         2:       return 8;
         default: return 3;
      endcase
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g_sw
      localparam int SW = cfg_w(gi);
      localparam int SD = cfg_d(gi);
      localparam int SN = SW / SD;
      localparam int SC = $clog2(SN + 1);

      logic          s_iv, s_ir, s_sm, s_ov, s_or, s_g, s_l, s_e;
      logic [SW-1:0] s_a, s_b;
      logic [SC-1:0] s_nd;
      int            sq[$];
      int            acc_cnt = 0;
      int            res_cnt = 0;
      logic          fin = 1'b0;

      mag_cmp_seq #(.WIDTH(SW), .DIGIT(SD)) u_dut (
         .clk         (clk),
         .rst_n       (sw_rst_n),
         .in_valid    (s_iv),
         .in_ready    (s_ir),
         .a           (s_a),
         .b           (s_b),
         .signed_mode (s_sm),
         .out_valid   (s_ov),
         .out_ready   (s_or),
         .g           (s_g),
         .l           (s_l),
         .e           (s_e),
         .ndig        (s_nd)
      );

      function automatic int model(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic sm);
         logic signed [SW-1:0] sx;
         logic signed [SW-1:0] sy;
         int   nd;
         int   r;
         logic found;
         sx = x; sy = y;
         nd = SN; found = 1'b0;
         for (int k = 0; k < SN; k++) begin
            if (!found && (x[(SN-1-k)*SD +: SD] != y[(SN-1-k)*SD +: SD])) begin
               nd    = k + 1;
               found = 1'b1;
            end
         end
         if (sm) r = (sx > sy) ? 4 : ((sx < sy) ? 2 : 1);
         else    r = (x > y)   ? 4 : ((x < y)   ? 2 : 1);
         return (nd << 3) | r;
      endfunction

      always @(negedge clk) begin
         if (sw_rst_n) begin
            if (s_iv && s_ir) begin
               sq.push_back(model(s_a, s_b, s_sm));
               acc_cnt++;
            end
            if (s_ov && s_or) begin
               if (sq.size() == 0) begin
                  chk($sformatf("sw%0d_unexpected", gi), 32'd1, 32'd0);
               end else begin
                  int pk;
                  pk = sq.pop_front();
                  chk($sformatf("sw%0d_gle", gi), 32'({s_g, s_l, s_e}), 32'(pk & 7));
                  chk($sformatf("sw%0d_ndig", gi), 32'(s_nd), 32'(pk >> 3));
               end
               res_cnt++;
            end
         end
      end

      initial begin
         int            cyc;
         int            last_acc;
         int            kind;
         logic [SW-1:0] ra;
         cyc = 0; last_acc = 0;
         s_iv = 1'b0; s_or = 1'b0; s_a = '0; s_b = '0; s_sm = 1'b0;
         @(posedge sw_rst_n);
         while (res_cnt < 2*NPAIR && cyc < 80000) begin
            @(posedge clk); #1;
            cyc++;
            s_or = ($urandom_range(0, 3) != 0);
            if (acc_cnt != last_acc) begin
               last_acc = acc_cnt;
               s_iv     = 1'b0;
            end
            if (!s_iv && acc_cnt < 2*NPAIR && $urandom_range(0, 2) != 0) begin
               kind = $urandom_range(0, 2);
               ra   = SW'($urandom);
               s_a  = ra;
               case (kind)
                  0:       s_b = SW'($urandom);
                  1:       s_b = ra;
                  default: s_b = ra ^ (SW'(1) << $urandom_range(0, SW-1));
               endcase
               s_sm = (acc_cnt >= NPAIR);
               s_iv = 1'b1;
            end
         end
         chk($sformatf("sw%0d_count", gi), 32'(res_cnt), 32'(2*NPAIR));
         chk($sformatf("sw%0d_qempty", gi), 32'(sq.size()), 32'd0);
         fin = 1'b1;
      end
   end

   initial begin
      sw_rst_n = 1'b0;
      #23 sw_rst_n = 1'b1;
   end

   initial begin
      int cyc;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; signed_mode = 1'b0;
      #12;
      chk("rst_ir", 32'(in_ready), 32'd1);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_gle", 32'({g, l, e}), 32'd0);
      chk("rst_ndig", 32'(ndig), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_cmp("eq",    16'h1234, 16'h1234, 1'b0, 0, 0, 1, 4, 4); release_res("eq");
      run_cmp("gt_u",  16'h9000, 16'h1000, 1'b0, 1, 0, 0, 1, 1); release_res("gt_u");
      run_cmp("lt_s",  16'h9000, 16'h1000, 1'b1, 0, 1, 0, 1, 1); release_res("lt_s");
      run_cmp("lt_u0", 16'h00FE, 16'h00FF, 1'b0, 0, 1, 0, 4, 4); release_res("lt_u0");
      run_cmp("neg_s", 16'hFFFF, 16'h0000, 1'b1, 0, 1, 0, 1, 1); release_res("neg_s");

      // Result held under backpressure; a stray request meanwhile must be dropped.
      run_cmp("bp", 16'h9000, 16'h1000, 1'b0, 1, 0, 0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_valid = (i == 1);
         a = 16'h0000; b = 16'h0001;
         chk("bp_gle", 32'({g, l, e}), 32'b100);
         chk("bp_ndig", 32'(ndig), 32'd1);
         chk("bp_ir", 32'(in_ready), 32'd0);
         chk("bp_ov", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      release_res("bp");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp_noq", 32'(out_valid), 32'd0);
      end

      // Abort mid-compare after two digits have been examined.
      chk("ab_rdy", 32'(in_ready), 32'd1);
      a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("ab_ov", 32'(out_valid), 32'd0);
      chk("ab_ir", 32'(in_ready), 32'd1);
      chk("ab_gle", 32'({g, l, e}), 32'd0);
      chk("ab_ndig", 32'(ndig), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_cmp("ab_new", 16'h0005, 16'h0003, 1'b0, 1, 0, 0, 4, 4); release_res("ab_new");

      cyc = 0;
      while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin) && cyc < 90000) begin
         @(posedge clk);
         cyc++;
      end
      chk("sweep_wait", 32'(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
